// File: rtl/uart_queue_drain.sv
// uart_queue_drain: pops bytes from the send ring buffer and serialises each as an 8N1 UART frame.
module uart_queue_drain #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int PTR_WIDTH = 9
) (
  input  logic                 CLK,
  input  logic                 INITIALIZE,
  input  logic [PTR_WIDTH-1:0] QUEUE_T,
  input  logic [7:0]           QUEUE_DATA,
  output logic [PTR_WIDTH-1:0] QUEUE_S,
  output logic                 UART_TX,
  output logic                 BUSY,
  output logic                 SENT
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic [PTR_WIDTH-1:0] s_n;
  logic tx_n, busy_n, pop, tick;
  assign tick = cnt == '0;
  // The empty test uses the pre-edge write pointer, so a same-cycle write is seen one cycle later.
  assign pop = (QUEUE_S != QUEUE_T) && (state == IDLE || (state == STOP && tick));
  assign SENT = state == STOP && tick;
  always_comb begin
    state_n = state;
    idx_n = idx;
    shift_n = pop ? QUEUE_DATA : shift;
    s_n = QUEUE_S + PTR_WIDTH'(pop);
    tx_n = UART_TX;
    busy_n = BUSY;
    case (state)
      IDLE: if (pop) begin
        state_n = START;
        tx_n = 1'b0;
        busy_n = 1'b1;
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n = 3'd0;
        tx_n = shift[0];
      end
      DATA: if (tick) begin
        state_n = idx == 3'd7 ? STOP : DATA;
        idx_n = idx + 3'd1;
        tx_n = idx == 3'd7 ? 1'b1 : shift[idx + 3'd1];
      end
      STOP: if (tick) begin
        state_n = pop ? START : IDLE;
        tx_n = !pop;
        busy_n = pop;
      end
    endcase
    // Parked at zero while idle so a pop always reloads a full bit period.
    cnt_n = state_n == IDLE ? '0 : (tick || state == IDLE) ? CMAX : cnt - 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      QUEUE_S <= '0;
      UART_TX <= 1'b1;
      BUSY <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      QUEUE_S <= s_n;
      UART_TX <= tx_n;
      BUSY <= busy_n;
    end
  end
endmodule

// File: tb/tb_uart_queue_drain.sv
// tb_uart_queue_drain: randomized and directed checks against a frame-position reference model.
module tb_uart_queue_drain;
  localparam int CPB = 4;
  localparam int PW = 3;
  localparam int DEPTH = 1 << PW;
  localparam int LAST = 10 * CPB - 1;
  logic clk = 0;
  logic init = 1;
  logic [PW-1:0] qt_in = '0;
  logic [7:0] qdata = '0;
  logic [PW-1:0] queue_s;
  logic tx, busy, sent;
  int n_tests = 0;
  int n_fail = 0;
  int pos = -1;
  int m_s = 0;
  int qt = 0;
  bit scramble = 0;
  logic [7:0] m_byte = '0;
  logic [7:0] mem [DEPTH];
  uart_queue_drain #(.CLKS_PER_BIT(CPB), .PTR_WIDTH(PW)) dut (
    .CLK(clk), .INITIALIZE(init), .QUEUE_T(qt_in), .QUEUE_DATA(qdata),
    .QUEUE_S(queue_s), .UART_TX(tx), .BUSY(busy), .SENT(sent)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic int exp_tx();
    if (pos < 0) return 1;
    if (pos < CPB) return 0;
    if (pos < 9 * CPB) return int'(m_byte[pos / CPB - 1]);
    return 1;
  endfunction
  task automatic push(input logic [7:0] b);
    mem[qt] = b;
    qt = (qt + 1) % DEPTH;
  endtask
  function automatic int fill();
    return (qt - m_s + DEPTH) % DEPTH;
  endfunction
  // One clock: check outputs after the last edge, then drive inputs and advance the model across the next edge.
  task automatic cyc(input bit rst);
    bit done, pop;
    @(negedge clk);
    chk("tx", int'(tx), exp_tx());
    chk("busy", int'(busy), int'(pos >= 0));
    chk("sent", int'(sent), int'(pos == LAST));
    chk("queue_s", int'(queue_s), m_s);
    init = rst;
    qt_in = PW'(qt);
    done = pos < 0 || pos == LAST;
    pop = !rst && done && m_s != qt;
    qdata = (scramble && !pop) ? 8'($urandom) : mem[m_s];
    if (rst) begin
      pos = -1;
      m_s = 0;
    end else if (pop) begin
      m_byte = mem[m_s];
      m_s = (m_s + 1) % DEPTH;
      pos = 0;
    end else pos = done ? -1 : pos + 1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0);
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    cyc(1);
    cyc(1);
    cyc(1);
    run(100);
    push(8'hA5);
    cyc(0);
    cyc(0);
    chk("single_s", int'(queue_s), 1);
    run(50);
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    run(130);
    chk("b2b_s", int'(queue_s), 4);
    qt = 0;
    cyc(1);
    for (int i = 0; i < 7; i++) push(8'($urandom));
    run(7 * 40 + 5);
    chk("pre_wrap_s", int'(queue_s), 7);
    push(8'hC3);
    run(45);
    chk("wrap_s", int'(queue_s), 0);
    chk("wrap_idle", int'(busy), 0);
    push(8'h00);
    run(18);
    qt = 0;
    cyc(1);
    cyc(0);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_s", int'(queue_s), 0);
    run(60);
    scramble = 1;
    push(8'h3C);
    run(45);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        int k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) if (fill() < DEPTH - 1) push(8'($urandom));
      end
      if ($urandom_range(0, 799) == 0) begin
        qt = 0;
        cyc(1);
      end else cyc(0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
